cordic_angle_reducer: RTL
=========================

# cordic_angle_reducer

Front-end stage for the CORDIC pipeline in circular rotation mode. It takes an arbitrary signed fixed-point angle and reduces it to the pipeline's convergence range [-pi/2, pi/2] using a multi-cycle iterative state machine. It emits pre-loaded x/y/z seed values, mode and rotation-enable, plus a negate flag that the output post-stage uses to sign-flip the pipeline's cos/sin results. Transfers use valid/ready handshakes on both sides.

## Interface
- INTEGER_BITS, 8, integer bits including sign
- FRACTIONAL_BITS, 8, fractional bits
- FIXED_POINT_BITS, INTEGER_BITS+FRACTIONAL_BITS, total word width
- i_clk  in  1  clock
- i_rst  in  1  reset: synchronous, active-high; clock i_clk
- i_valid  in  1  input angle valid
- o_ready  out  1  block can accept an angle; high only in IDLE
- i_angle  in  FIXED_POINT_BITS  signed angle in radians
- o_valid  out  1  reduced result valid
- i_ready  in  1  downstream accepts result; tie high when feeding the CORDIC pipeline directly
- o_x  out  FIXED_POINT_BITS  seed x = KINV (1/K ≈ 0.60725, Q8.8 = 0x009B)
- o_y  out  FIXED_POINT_BITS  seed y = 0
- o_z  out  FIXED_POINT_BITS  reduced angle, signed, within [-pi/2, pi/2]
- o_mode  out  2 (signed)  always +1 (circular)
- o_rot_en  out  1  always 1 (rotation)
- o_negate  out  1  downstream must negate the final x and y

## Operation
- Constants are round(c·2^FRACTIONAL_BITS). In Q8.8: PI = 804 (0x0324), TWO_PI = 1608 (0x0648), HALF_PI = 402 (0x0192), KINV = 155 (0x009B).
- All comparisons are signed.
- Internal accumulator is FIXED_POINT_BITS+1 bits wide. Each step moves z toward zero, so no overflow can occur.
- FSM states:
  - **IDLE**: o_ready = 1. When i_valid && o_ready, load z ← sign-extended i_angle and go to REDUCE.
  - **REDUCE**: one action per cycle:
    - If z > PI: z ← z − TWO_PI and stay in REDUCE.
    - Else if z < −PI: z ← z + TWO_PI and stay in REDUCE.
    - Otherwise, fold in this same cycle, then go to OUT:
      - z > HALF_PI: o_z ← z − PI, o_negate ← 1.
      - z < −HALF_PI: o_z ← z + PI, o_negate ← 1.
      - Otherwise: o_z ← z, o_negate ← 0.
      - In all three cases, o_x ← KINV and o_y ← 0.
  - **OUT**: o_valid = 1. Outputs are held stable until i_ready; on i_valid... no: on o_valid && i_ready, go to IDLE.
- Range boundaries are inclusive:
  - z == PI and z == −PI stay in range (no further step).
  - z == ±HALF_PI is not folded.
  - z == PI folds to 0 with o_negate = 1.
- i_valid is ignored outside IDLE. No input buffering.
- o_x/o_y/o_z/o_negate are registered and hold their last values after leaving OUT.
- o_mode and o_rot_en are constant.

## Timing
- Reset values: state IDLE, o_ready 1, o_valid 0, o_x 0, o_y 0, o_z 0, o_negate 0. o_mode = 1 and o_rot_en = 1 are constants.
- Latency: with the handshake in cycle t and k range steps, o_valid rises in cycle t+2+k.
- k ≤ ceil(2^(INTEGER_BITS−1)/TWO_PI). The worst case for Q8.8 is k = 20, giving t+22.
- With i_ready held high, OUT lasts 1 cycle and o_ready returns in cycle t+3+k.
- Throughput: one angle per (3+k) cycles.
- Backpressure: while in OUT with i_ready = 0, all outputs are frozen and o_ready = 0.
- Reset mid-operation in any state: in the next cycle the block is in IDLE with all reset values, and the in-flight angle is discarded.

## Test plan
- i_angle 0x0100 (1.0), i_ready = 1 → o_valid at t+2; o_z 0x0100, o_negate 0, o_x 0x009B, o_y 0, o_mode 1, o_rot_en 1.
- i_angle 0x0200 (2.0) → t+2; o_z 0xFEDC (−292), o_negate 1. Also i_angle 0x0324 → o_z 0x0000, o_negate 1.
- i_angle 0x0A00 (10.0) → k = 2 (2560→952→−656), fold to o_z 0x0094, o_negate 1; o_valid at t+4.
- i_angle 0x8000 (−128.0) → k = 20, z = −608, fold to o_z 0x00C4, o_negate 1; o_valid at t+22.
- Backpressure: i_ready = 0 for 5 cycles in OUT with i_valid held high → o_z stable, o_ready 0, no new capture. i_ready = 1 → o_ready 1 in the next cycle, then the new angle is accepted.
- i_rst asserted at t+5 during the −128.0 reduction → next cycle o_ready 1, o_valid 0, o_z 0, o_negate 0. A fresh 0x0100 afterwards gives the scenario-1 result.

Source files
------------

// File: rtl/cordic_angle_reducer.sv
// Angle range reducer in front of a circular-rotation CORDIC pipeline.
// An iterative FSM wraps an arbitrary signed fixed-point angle into
// [-pi, pi] by whole turns. It then folds the angle into [-pi/2, pi/2].
// The fold is recorded in o_negate, so that downstream can sign-flip cos/sin.
module cordic_angle_reducer #(
  parameter int INTEGER_BITS     = 8,
  parameter int FRACTIONAL_BITS  = 8,
  parameter int FIXED_POINT_BITS = INTEGER_BITS + FRACTIONAL_BITS
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               i_valid,
  output logic                               o_ready,
  input  logic signed [FIXED_POINT_BITS-1:0] i_angle,
  output logic                               o_valid,
  input  logic                               i_ready,
  output logic signed [FIXED_POINT_BITS-1:0] o_x,
  output logic signed [FIXED_POINT_BITS-1:0] o_y,
  output logic signed [FIXED_POINT_BITS-1:0] o_z,
  output logic signed [1:0]                  o_mode,
  output logic                               o_rot_en,
  output logic                               o_negate
);

  // One guard bit so that the first wrap of a full-scale angle cannot overflow.
  localparam int  ACC_W = FIXED_POINT_BITS + 1;
  localparam real SCALE = 2.0 ** FRACTIONAL_BITS;

  localparam logic signed [ACC_W-1:0] PI      = ACC_W'($rtoi(3.141592653589793 * SCALE + 0.5));
  localparam logic signed [ACC_W-1:0] TWO_PI  = ACC_W'($rtoi(6.283185307179586 * SCALE + 0.5));
  localparam logic signed [ACC_W-1:0] HALF_PI = ACC_W'($rtoi(1.570796326794897 * SCALE + 0.5));
  localparam logic signed [ACC_W-1:0] NEG_PI      = -PI;
  localparam logic signed [ACC_W-1:0] NEG_HALF_PI = -HALF_PI;
  localparam logic signed [FIXED_POINT_BITS-1:0] KINV =
    FIXED_POINT_BITS'($rtoi(0.6072529350088813 * SCALE + 0.5));

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    OUT    = 2'd2
  } state_t;

  state_t                   state;
  logic signed [ACC_W-1:0]  z_acc;

  // The folded angle is always within +/-pi/2, so dropping the guard bit is lossless.
  function automatic logic signed [FIXED_POINT_BITS-1:0] to_word(
    input logic signed [ACC_W-1:0] v
  );
    return v[FIXED_POINT_BITS-1:0];
  endfunction

  assign o_ready  = (state == IDLE);
  assign o_valid  = (state == OUT);
  assign o_mode   = 2'sd1;
  assign o_rot_en = 1'b1;

  // Control FSM: capture the angle, wrap by 2*pi per cycle, then fold and present the result.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      o_x      <= '0;
      o_y      <= '0;
      o_z      <= '0;
      o_negate <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            z_acc <= {i_angle[FIXED_POINT_BITS-1], i_angle};
            state <= REDUCE;
          end
        end
        REDUCE: begin
          if (z_acc > PI) begin
            z_acc <= z_acc - TWO_PI;
          end else if (z_acc < NEG_PI) begin
            z_acc <= z_acc + TWO_PI;
          end else begin
            if (z_acc > HALF_PI) begin
              o_z      <= to_word(z_acc - PI);
              o_negate <= 1'b1;
            end else if (z_acc < NEG_HALF_PI) begin
              o_z      <= to_word(z_acc + PI);
              o_negate <= 1'b1;
            end else begin
              o_z      <= to_word(z_acc);
              o_negate <= 1'b0;
            end
            o_x   <= KINV;
            o_y   <= '0;
            state <= OUT;
          end
        end
        OUT: begin
          if (i_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
